// File: rtl/lfsr_rng_if.sv
// lfsr_rng draw/seed bundle.
// Master drives control; slave returns draws.
interface lfsr_rng_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 2
);
  logic             MODE;
  logic             SEED_LD;
  logic [WIDTH-1:0] SEED_IN;
  logic             REQ;
  logic             BUSY;
  logic             VALID;
  logic [OUT_W-1:0] RAND;

  modport master (
    output MODE, SEED_LD, SEED_IN, REQ,
    input  BUSY, VALID, RAND
  );

  modport slave (
    input  MODE, SEED_LD, SEED_IN, REQ,
    output BUSY, VALID, RAND
  );
endinterface

// File: rtl/lfsr_rng.sv
// Galois LFSR / legacy counter RNG.
// Draws OUT_W bits per request via REQ/VALID.
module lfsr_rng #(
  parameter int             WIDTH = 16,
  parameter int             OUT_W = 2,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hACE1)
) (
  input  logic       CLK,
  input  logic       RST,
  lfsr_rng_if.slave  bus
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_lfsr;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [OUT_W-1:0] col_q;
  logic [OUT_W-1:0] col_shift;
  logic             busy_q;
  logic             valid_q;
  logic [OUT_W-1:0] rand_q;

  // Next state: reset > reload > lockup > advance.
  always_comb begin
    s_lfsr = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
    s_d    = s_q + WIDTH'(1);
    if (RST) begin
      s_d = bus.MODE ? SEED : '0;
    end else if (bus.SEED_LD) begin
      s_d = bus.SEED_IN;
    end else if (bus.MODE && (s_q == '0)) begin
      s_d = SEED;
    end else if (bus.MODE) begin
      s_d = s_lfsr;
    end
  end

  // Free-running state register.
  always_ff @(posedge CLK) begin
    s_q <= s_d;
  end

  // First sample ends up in the MSB.
  always_comb begin
    col_shift = (col_q << 1) | OUT_W'(s_q[0]);
  end

  // Draw FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rand_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.REQ) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        COLLECT: begin
          col_q <= col_shift;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            rand_q  <= bus.MODE ? col_shift
                                : s_q[OUT_W-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY  = busy_q;
  assign bus.VALID = valid_q;
  assign bus.RAND  = rand_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng.
// Draws are scoreboarded through exp_q.
module tb_lfsr_rng;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lfsr_rng_if #(.WIDTH(16), .OUT_W(2)) bus ();
  lfsr_rng_if #(.WIDTH(16), .OUT_W(4)) bus4 ();

  lfsr_rng #(.WIDTH(16), .OUT_W(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  lfsr_rng #(.WIDTH(16), .OUT_W(4)) dut4 (
    .CLK (clk),
    .RST (rst),
    .bus (bus4)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  function automatic logic [15:0] step(
    input logic [15:0] s
  );
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.MODE = 1'b1;
    bus4.MODE = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (dut.s_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_s1: got %h want ace1", dut.s_q);
    end
    checks++;
    if (bus.BUSY !== 1'b0 || bus.VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b%b want 00",
               bus.BUSY, bus.VALID);
    end
    checks++;
    if (bus.RAND !== 2'b00) begin
      errors++;
      $display("FAIL reset_rand: got %b want 00", bus.RAND);
    end
    checks++;
    if (dut4.s_q !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_s4: got %h want ace1", dut4.s_q);
    end
    bus.MODE = 1'b0;
    tick();
    checks++;
    if (dut.s_q !== 16'h0000) begin
      errors++;
      $display("FAIL reset_s0: got %h want 0000", dut.s_q);
    end
  endtask

  task automatic test_period;
    logic [15:0] m;
    logic [15:0] first [4];
    int zeros;
    int mism;
    int ret;
    first[0] = 16'hE270;
    first[1] = 16'h7138;
    first[2] = 16'h389C;
    first[3] = 16'h1C4E;
    zeros = 0;
    mism = 0;
    ret = 0;
    bus.MODE = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m = 16'hACE1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      m = step(m);
      if (dut.s_q == 16'h0000) zeros++;
      if (dut.s_q !== m) mism++;
      if (dut.s_q == 16'hACE1 && ret == 0) ret = i;
      if (i <= 4) begin
        checks++;
        if (dut.s_q !== first[i-1]) begin
          errors++;
          $display("FAIL period_seq%0d: got %h want %h",
                   i, dut.s_q, first[i-1]);
        end
      end
    end
    checks++;
    if (zeros != 0) begin
      errors++;
      $display("FAIL period_zero: got %0d want 0", zeros);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL period_track: got %0d want 0", mism);
    end
    checks++;
    if (ret != 65535) begin
      errors++;
      $display("FAIL period_len: got %0d want 65535", ret);
    end
  endtask

  task automatic test_reseed_draw;
    logic [15:0] se [3];
    logic [3:0] e;
    se[0] = 16'hEE03;
    se[1] = 16'hC301;
    se[2] = 16'hD580;
    bus4.MODE = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus4.SEED_LD = 1'b1;
    bus4.SEED_IN = 16'h000F;
    tick();
    bus4.SEED_LD = 1'b0;
    checks++;
    if (dut4.s_q !== 16'h000F) begin
      errors++;
      $display("FAIL seed_ld: got %h want 000f", dut4.s_q);
    end
    bus4.REQ = 1'b1;
    exp_q.push_back(4'b1110);
    tick();
    bus4.REQ = 1'b0;
    checks++;
    if (dut4.s_q !== 16'hB407 || bus4.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL draw4_e1: got %h/%b want b407/1",
               dut4.s_q, bus4.BUSY);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (dut4.s_q !== se[j] || bus4.BUSY !== 1'b1 ||
          bus4.VALID !== 1'b0) begin
        errors++;
        $display("FAIL draw4_e%0d: got %h/%b%b want %h/10",
                 j + 2, dut4.s_q, bus4.BUSY, bus4.VALID,
                 se[j]);
      end
    end
    tick();
    checks++;
    if (bus4.VALID !== 1'b1 || bus4.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL draw4_done: got %b%b want 01",
               bus4.BUSY, bus4.VALID);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL draw4_sb: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if (bus4.RAND !== e) begin
        errors++;
        $display("FAIL draw4_rand: got %b want %b",
                 bus4.RAND, e);
      end
    end
    tick();
    checks++;
    if (bus4.VALID !== 1'b0 || bus4.RAND !== 4'b1110) begin
      errors++;
      $display("FAIL draw4_hold: got %b/%b want 0/1110",
               bus4.VALID, bus4.RAND);
    end
  endtask

  task automatic test_counter;
    logic [15:0] w [4];
    logic [3:0] e;
    w[0] = 16'hFFFE;
    w[1] = 16'hFFFF;
    w[2] = 16'h0000;
    w[3] = 16'h0001;
    bus.MODE = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.REQ = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    bus.REQ = 1'b0;
    checks++;
    if (dut.s_q !== 16'h0001 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL cnt_e0: got %h/%b want 0001/1",
               dut.s_q, bus.BUSY);
    end
    tick();
    tick();
    checks++;
    if (bus.VALID !== 1'b1 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL cnt_valid: got %b%b want 01",
               bus.BUSY, bus.VALID);
    end
    checks++;
    e = exp_q.pop_front();
    if ({2'b00, bus.RAND} !== e) begin
      errors++;
      $display("FAIL cnt_rand: got %b want %b", bus.RAND, e);
    end
    bus.SEED_LD = 1'b1;
    bus.SEED_IN = 16'hFFFE;
    tick();
    bus.SEED_LD = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      checks++;
      if (dut.s_q !== w[j]) begin
        errors++;
        $display("FAIL cnt_wrap%0d: got %h want %h",
                 j, dut.s_q, w[j]);
      end
    end
  endtask

  task automatic test_lockup;
    logic [15:0] w [3];
    w[0] = 16'h0000;
    w[1] = 16'hACE1;
    w[2] = 16'hE270;
    bus.MODE = 1'b1;
    bus.SEED_LD = 1'b1;
    bus.SEED_IN = 16'h0000;
    tick();
    bus.SEED_LD = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) tick();
      checks++;
      if (dut.s_q !== w[j]) begin
        errors++;
        $display("FAIL lockup%0d: got %h want %h",
                 j, dut.s_q, w[j]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] m;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0] e;
    int ph;
    bus.MODE = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m = 16'hACE1;
    bus.REQ = 1'b1;
    for (int j = 0; j < 30; j++) begin
      ph = j % 3;
      if (ph == 0) begin
        a = step(m);
        b = step(a);
        exp_q.push_back({2'b00, a[0], b[0]});
      end
      tick();
      m = step(m);
      checks++;
      if (bus.VALID !== (ph == 2) ||
          bus.BUSY !== (ph != 2)) begin
        errors++;
        $display("FAIL b2b_hs%0d: got %b%b want %b%b",
                 j, bus.BUSY, bus.VALID,
                 ph != 2, ph == 2);
      end
      if (ph == 2) begin
        checks++;
        e = exp_q.pop_front();
        if ({2'b00, bus.RAND} !== e) begin
          errors++;
          $display("FAIL b2b_rand%0d: got %b want %b",
                   j, bus.RAND, e[1:0]);
        end
      end
    end
    bus.REQ = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d want 0",
               exp_q.size());
    end
  endtask

  task automatic test_req_during_busy;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0] e;
    int extra;
    bus.MODE = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = step(16'hACE1);
    b = step(a);
    exp_q.push_back({2'b00, a[0], b[0]});
    bus.REQ = 1'b1;
    tick();
    tick();
    bus.REQ = 1'b0;
    tick();
    checks++;
    if (bus.VALID !== 1'b1) begin
      errors++;
      $display("FAIL rdb_valid: got %b want 1", bus.VALID);
    end
    checks++;
    e = exp_q.pop_front();
    if ({2'b00, bus.RAND} !== e) begin
      errors++;
      $display("FAIL rdb_rand: got %b want %b",
               bus.RAND, e[1:0]);
    end
    extra = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (bus.VALID !== 1'b0 || bus.BUSY !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL rdb_extra: got %0d want 0", extra);
    end
  endtask

  task automatic test_rst_mid;
    int extra;
    bus.MODE = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.RAND !== 2'b10) begin
      errors++;
      $display("FAIL rmid_pre: got %b want 10", bus.RAND);
    end
    bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
    tick();
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: got %b want 1", bus.BUSY);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.VALID !== 1'b0 ||
        bus.RAND !== 2'b00) begin
      errors++;
      $display("FAIL rmid_clr: got %b%b/%b want 00/00",
               bus.BUSY, bus.VALID, bus.RAND);
    end
    extra = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (bus.VALID !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL rmid_novalid: got %0d want 0", extra);
    end
  endtask

  initial begin
    bus.MODE = 1'b1;
    bus.SEED_LD = 1'b0;
    bus.SEED_IN = '0;
    bus.REQ = 1'b0;
    bus4.MODE = 1'b1;
    bus4.SEED_LD = 1'b0;
    bus4.SEED_IN = '0;
    bus4.REQ = 1'b0;
    test_reset();
    test_period();
    test_reseed_draw();
    test_counter();
    test_lockup();
    test_back_to_back();
    test_req_during_busy();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised pseudo-random number generator; successor to the 2-bit free-running counter RNG. Holds a WIDTH-bit Galois LFSR (or, in legacy mode, a plain up-counter) that advances every clock. Consumers draw OUT_W-bit values through a REQ/VALID handshake. Seed load and zero-state lockup recovery are included, so the block can feed game/arbitration logic that needs repeatable or reseedable sequences.

## Interface
- WIDTH, 16: state register width, 2..32.
- OUT_W, 2: bits per draw, 1..WIDTH.
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits; default is x^16+x^14+x^13+x^11+1.
- SEED, 16'hACE1: reset and lockup-recovery state, WIDTH bits, must be nonzero.

- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- MODE  in  1  0 = counter (legacy), 1 = LFSR.
- SEED_LD  in  1  load SEED_IN into state at this edge.
- SEED_IN  in  WIDTH  seed value.
- REQ  in  1  draw request, sampled only when idle.
- BUSY  out  1  draw in progress.
- VALID  out  1  one-cycle pulse, RAND just updated.
- RAND  out  OUT_W  last completed draw, held until next completion.

## Operation
- State register S, updated every edge. Priority: RST > SEED_LD > lockup > advance.
  - RST: S <= (MODE ? SEED : 0).
  - SEED_LD: S <= SEED_IN.
  - Lockup: MODE=1 and S==0 → S <= SEED.
  - Advance, MODE=1: S <= (S >> 1) ^ (S[0] ? TAPS : 0).
  - Advance, MODE=0: S <= S + 1, wrapping modulo 2^WIDTH.
- MODE may change on any cycle. S is not reset on a mode change; the next advance uses the new rule.
- Draw FSM states:
  - IDLE: REQ=1 → COLLECT, cnt <= 0.
  - COLLECT: one sample per edge, cnt increments. At the OUT_W-th sample: RAND <= the collected value, VALID <= 1, → IDLE.
- Sample value: in LFSR mode, S[0] of the pre-edge state is shifted into the collect register at the LSB, so the first sample ends up as the MSB. In counter mode, the final sample sets RAND <= S[OUT_W-1:0] of the pre-edge state; earlier samples are discarded.
- REQ is ignored while BUSY=1. REQ=1 in a cycle where VALID=1 (FSM already IDLE) starts a new draw, so peak throughput is one draw per OUT_W+1 cycles.
- SEED_LD or lockup reload during COLLECT does not abort the draw. Later samples come from the reloaded sequence.
- SEED_IN=0 with MODE=1: S becomes 0 for one cycle, then the lockup rule loads SEED. A bit sampled during that cycle is 0.
- MODE change during COLLECT: each sample uses the MODE current at that edge.

## Timing
- Reset values: BUSY=0, VALID=0, RAND=0, FSM=IDLE, cnt=0, S as above.
- RST asserted mid-draw aborts the draw immediately; no VALID pulse.
- REQ sampled high at edge k → BUSY=1 after edge k through edge k+OUT_W. Samples are taken at edges k+1..k+OUT_W. VALID=1 and the new RAND are visible after edge k+OUT_W, for exactly one cycle (VALID only; RAND holds).
- BUSY and VALID are never high together.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Period: defaults, MODE=1, no SEED_LD, run 65535 edges after reset → S sequence starts ACE1, E270, 7138, 389C, 1C4E. S never 0. S==ACE1 again exactly at edge 65535.
- Draw with reseed, OUT_W=4, MODE=1: SEED_LD with SEED_IN=16'h000F at e0, REQ at e1 → S goes B407, EE03, C301, D580. RAND=4'b1110 and VALID=1 after e5. BUSY high after e1..e5.
- Legacy counter, OUT_W=2, MODE=0: release reset, REQ at first edge e0 → RAND=2'b10, VALID after e2. Run 2^16 edges → S wraps 16'hFFFF→0.
- Lockup: MODE=1, SEED_LD with SEED_IN=0 → S=0 for one cycle, then S=ACE1, then E270.
- Handshake corners: REQ held high continuously with OUT_W=2 → VALID every 3rd cycle, never with BUSY. REQ pulses during BUSY produce no extra draw. RST asserted mid-COLLECT → BUSY, VALID, RAND=0 next cycle and no VALID pulse afterward.
